pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register for the five-stage CPU. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries a WIDTH-bit payload (e.g. {Instr, pc_add4} = 64 bits) with a valid/ready handshake, a flush (bubble) input and an optional 2-entry skid mode. The skid mode breaks the combinational ready path between stages.

Parameters:
WIDTH, 64, payload width in bits (>=1)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
RESET_VAL, 0, WIDTH-bit value loaded into data registers on reset (and on flush when CLEAR_ON_FLUSH=1)
CLEAR_ON_FLUSH, 1, 1 = flush also overwrites data registers with RESET_VAL; 0 = data retained, only valid cleared

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous bubble insert: discards all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream accepts payload this cycle
out_data  output  WIDTH  payload presented downstream (main register)
count  output  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Transfer events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Priority: reset > flush > normal operation.
- Reset: state EMPTY; out_valid=0; count=0; main and skid registers = RESET_VAL. In SKID=1 mode, in_ready=1 in the cycle after reset.
- Flush: next state EMPTY; count=0. A payload accepted in the flush cycle is dropped. A pop in the flush cycle still counts as a downstream transfer. Data registers go to RESET_VAL only when CLEAR_ON_FLUSH=1.
- out_data always equals the main register. out_valid = (state != EMPTY). out_data is not guaranteed meaningful when out_valid=0.
- SKID=1: states EMPTY, ONE, TWO; in_ready = (state != TWO), driven purely from the state register with no input-to-output combinational path.
  - EMPTY: acc -> ONE, main<=in_data; else stay.
  - ONE: acc&pop -> ONE, main<=in_data. pop only -> EMPTY. acc only -> TWO, skid<=in_data. Neither -> hold.
  - TWO: pop -> ONE, main<=skid. Otherwise hold. No acceptance possible since in_ready=0.
- SKID=0: states EMPTY, ONE only; in_ready = ~out_valid | out_ready (combinational).
  - acc -> main<=in_data, state ONE.
  - pop without acc -> EMPTY.
  - count never exceeds 1.
- Latency: an accepted payload appears on out_data/out_valid the next cycle (1 cycle, both modes). Throughput is 1 payload/cycle when out_ready is held high.
- Ordering: strict FIFO. Payloads are never duplicated or dropped except by flush or reset.
- Stall: out_ready=0 holds main (and skid) stable. out_data must not change while out_valid=1 and out_ready=0.
- Boundaries:
  - TWO with in_valid=1 and out_ready=0: hold indefinitely, in_ready=0.
  - flush while TWO: both entries discarded.
  - reset mid-stall: same result as power-up reset.
- count = 0/1/2 for EMPTY/ONE/TWO, registered.

Test Plan:
1. Reset, then stream A=0x1, B=0x2, C=0x3 with out_ready=1 and in_valid=1 each cycle -> out_data 0x1, 0x2, 0x3 on consecutive cycles starting 1 cycle after each accept; count stays 1; in_ready stays 1.
2. SKID=1: accept A, B with out_ready=0 -> count=2, in_ready=0, out_data=A held. Raise out_ready for 2 cycles -> out A then B; count 2->1->0.
3. SKID=1, state TWO (A,B) with flush=1 and in_valid=1 (C) -> next cycle out_valid=0, count=0, in_ready=1. With CLEAR_ON_FLUSH=1, out_data=RESET_VAL. C is never output.
4. Simultaneous acc and pop in ONE (main=A, input B) -> next cycle out_data=B, count=1, and the skid register is unused.
5. SKID=0, main=A, out_ready=0 -> in_ready=0 and B is not accepted. Raise out_ready with in_valid=1 -> in_ready=1 in the same cycle, out_data=B next cycle.
6. Reset asserted while in TWO with out_ready=0 -> next cycle count=0, out_valid=0, out_data=RESET_VAL, in_ready=1 (SKID=1).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a flush input.
// SKID=1 builds a 2-entry skid buffer. Its in_ready comes from a register, which
// breaks the combinational ready chain between stages.
// SKID=0 builds a single register. Its in_ready is combinational from out_ready.
module pipe_stage_reg #(
    parameter int                 WIDTH          = 64,
    parameter int                 SKID           = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL      = {WIDTH{1'b0}},
    parameter int                 CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    localparam bit SKID_EN  = (SKID != 0);
    localparam bit CLEAR_EN = (CLEAR_ON_FLUSH != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [1:0]       count_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             acc_s;
    logic             pop_s;

    // Number of held entries for a given state.
    function automatic logic [1:0] count_of(input state_t s);
        logic [1:0] c;
        case (s)
            ST_EMPTY: c = 2'd0;
            ST_ONE:   c = 2'd1;
            ST_TWO:   c = 2'd2;
            default:  c = 2'd0;
        endcase
        return c;
    endfunction

    // In skid mode, ready depends only on the state register.
    // In single-register mode, ready looks through to downstream.
    assign in_ready  = SKID_EN ? in_ready_q : (~out_valid_q | out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = count_q;

    assign acc_s = in_valid & in_ready;
    assign pop_s = out_valid_q & out_ready;

    // Next-state and data-path selection.
    // A flush overrides any accept or pop that happens in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_EN) begin
                main_d = RESET_VAL;
                skid_d = RESET_VAL;
            end else begin
                main_d = main_q;
                skid_d = skid_q;
            end
        end else if (SKID_EN) begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_s) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && pop_s) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else if (acc_s) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            // Single register: an accept while full always coincides with a pop.
            if (acc_s) begin
                main_d  = in_data;
                state_d = ST_ONE;
            end else if (pop_s) begin
                state_d = ST_EMPTY;
            end else begin
                state_d = state_q;
            end
        end
    end

    // State, data and registered status outputs. Reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            count_q     <= count_of(state_d);
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. It has two instances.
// The skid instance (SKID=1) clears its data on flush.
// The single-register instance (SKID=0) keeps its data on flush.
module tb_pipe_stage_reg;

    localparam logic [15:0] S_RV = 16'hDEAD;
    localparam logic [15:0] N_RV = 16'h1234;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset, s_flush, s_in_valid, s_out_ready;
    logic [15:0] s_in_data;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [1:0]  s_count;

    logic        n_reset, n_flush, n_in_valid, n_out_ready;
    logic [15:0] n_in_data;
    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out_data;
    logic [1:0]  n_count;

    pipe_stage_reg #(.WIDTH(16), .SKID(1), .RESET_VAL(S_RV), .CLEAR_ON_FLUSH(1)) dut_s (
        .clk(clk), .reset(s_reset), .flush(s_flush), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_data(s_in_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .count(s_count));

    pipe_stage_reg #(.WIDTH(16), .SKID(0), .RESET_VAL(N_RV), .CLEAR_ON_FLUSH(0)) dut_n (
        .clk(clk), .reset(n_reset), .flush(n_flush), .in_valid(n_in_valid),
        .in_ready(n_in_ready), .in_data(n_in_data), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .out_data(n_out_data), .count(n_count));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // One directed vector: inputs for one cycle, and the expected outputs after that edge.
    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        ov;
        logic [15:0] od;
        logic        chk_od;
        logic [1:0]  cnt;
        logic        ir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [15:0] din, input logic ordy, input logic ov,
                                input logic [15:0] od, input logic chk_od,
                                input logic [1:0] cnt, input logic ir);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
        v.ov = ov; v.od = od; v.chk_od = chk_od; v.cnt = cnt; v.ir = ir;
        return v;
    endfunction

    // Reference model: the payloads each instance currently holds, oldest first.
    logic [15:0] sq[$];
    logic [15:0] nq[$];
    bit          s_clr, n_clr;   // data register is known to hold RESET_VAL
    bit          s_acc, s_pop, n_acc, n_pop;

    initial begin
        s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 16'h0; s_out_ready = 1'b0;
        n_reset = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = 16'h0; n_out_ready = 1'b0;

        // Skid instance: directed vectors.
        // Each row gives: rst, fl, iv, din, ordy -> ov, od, chk_od, cnt, ir.
        vecs.push_back(mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,S_RV,   1'b1,2'd0,1'b1)); // reset
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0001,1'b1, 1'b1,16'h0001,1'b1,2'd1,1'b1)); // stream A
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0002,1'b1, 1'b1,16'h0002,1'b1,2'd1,1'b1)); // stream B
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0003,1'b1, 1'b1,16'h0003,1'b1,2'd1,1'b1)); // stream C
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,2'd0,1'b1)); // drain
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0011,1'b0, 1'b1,16'h0011,1'b1,2'd1,1'b1)); // stall A
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0022,1'b0, 1'b1,16'h0011,1'b1,2'd2,1'b0)); // B into skid
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0033,1'b0, 1'b1,16'h0011,1'b1,2'd2,1'b0)); // TWO holds
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0022,1'b1,2'd1,1'b1)); // pop A
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,2'd0,1'b1)); // pop B
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0044,1'b0, 1'b1,16'h0044,1'b1,2'd1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0055,1'b0, 1'b1,16'h0044,1'b1,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,16'h0066,1'b0, 1'b0,S_RV,   1'b1,2'd0,1'b1)); // flush TWO
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0077,1'b0, 1'b1,16'h0077,1'b1,2'd1,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,16'h0088,1'b0, 1'b0,S_RV,   1'b1,2'd0,1'b1)); // flush drops acc
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,S_RV,   1'b1,2'd0,1'b1)); // nothing emerges
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0099,1'b0, 1'b1,16'h0099,1'b1,2'd1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h00AA,1'b1, 1'b1,16'h00AA,1'b1,2'd1,1'b1)); // acc+pop in ONE
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,2'd0,1'b1)); // skid was unused
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h00BB,1'b0, 1'b1,16'h00BB,1'b1,2'd1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h00CC,1'b0, 1'b1,16'h00BB,1'b1,2'd2,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,16'h00EE,1'b0, 1'b0,S_RV,   1'b1,2'd0,1'b1)); // reset in TWO

        foreach (vecs[i]) begin
            @(negedge clk);
            s_reset = vecs[i].rst; s_flush = vecs[i].fl; s_in_valid = vecs[i].iv;
            s_in_data = vecs[i].din; s_out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), {63'd0, s_out_valid}, {63'd0, vecs[i].ov});
            chk($sformatf("vec%0d count", i), {62'd0, s_count}, {62'd0, vecs[i].cnt});
            chk($sformatf("vec%0d in_ready", i), {63'd0, s_in_ready}, {63'd0, vecs[i].ir});
            if (vecs[i].chk_od)
                chk($sformatf("vec%0d out_data", i), {48'd0, s_out_data}, {48'd0, vecs[i].od});
        end

        // Single-register instance: combinational ready and flush that keeps the data.
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk("n reset out_valid", {63'd0, n_out_valid}, 64'd0);
        chk("n reset count", {62'd0, n_count}, 64'd0);
        chk("n reset out_data", {48'd0, n_out_data}, {48'd0, N_RV});
        @(negedge clk);
        n_reset = 1'b0; n_in_valid = 1'b1; n_in_data = 16'h000A; n_out_ready = 1'b0;
        @(posedge clk); #1;
        chk("n A out_valid", {63'd0, n_out_valid}, 64'd1);
        chk("n A out_data", {48'd0, n_out_data}, 64'h000A);
        @(negedge clk);
        n_in_data = 16'h000B;
        #1 chk("n stall in_ready", {63'd0, n_in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("n stall out_data", {48'd0, n_out_data}, 64'h000A);
        chk("n stall count", {62'd0, n_count}, 64'd1);
        @(negedge clk);
        n_out_ready = 1'b1;
        #1 chk("n release in_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("n B out_data", {48'd0, n_out_data}, 64'h000B);
        chk("n B count", {62'd0, n_count}, 64'd1);
        @(negedge clk);
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_flush = 1'b1;
        @(posedge clk); #1;
        chk("n flush out_valid", {63'd0, n_out_valid}, 64'd0);
        chk("n flush count", {62'd0, n_count}, 64'd0);
        chk("n flush keeps data", {48'd0, n_out_data}, 64'h000B);

        // Random phase: reset both instances, then compare them against the queue models.
        @(negedge clk);
        s_reset = 1'b1; n_reset = 1'b1; s_flush = 1'b0; n_flush = 1'b0;
        s_in_valid = 1'b0; n_in_valid = 1'b0;
        @(posedge clk);
        sq.delete(); nq.delete(); s_clr = 1'b1; n_clr = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            s_reset     = ($urandom_range(63) == 0);
            s_flush     = ($urandom_range(15) == 0);
            s_in_valid  = ($urandom_range(3) != 0);
            s_in_data   = 16'($urandom);
            s_out_ready = ($urandom_range(2) != 0) ? ((cyc / 100) % 2 == 0) : 1'($urandom);
            n_reset     = ($urandom_range(63) == 0);
            n_flush     = ($urandom_range(15) == 0);
            n_in_valid  = ($urandom_range(3) != 0);
            n_in_data   = 16'($urandom);
            n_out_ready = 1'($urandom);
            #1;
            // Model expectations for the current (pre-edge) state.
            chk("rnd s in_ready", {63'd0, s_in_ready}, {63'd0, (sq.size() < 2)});
            chk("rnd s out_valid", {63'd0, s_out_valid}, {63'd0, (sq.size() > 0)});
            chk("rnd s count", {62'd0, s_count}, 64'(sq.size()));
            if (sq.size() > 0) chk("rnd s out_data", {48'd0, s_out_data}, {48'd0, sq[0]});
            else if (s_clr) chk("rnd s out_data clr", {48'd0, s_out_data}, {48'd0, S_RV});
            chk("rnd n in_ready", {63'd0, n_in_ready}, {63'd0, (nq.size() == 0) || n_out_ready});
            chk("rnd n out_valid", {63'd0, n_out_valid}, {63'd0, (nq.size() > 0)});
            chk("rnd n count", {62'd0, n_count}, 64'(nq.size()));
            if (nq.size() > 0) chk("rnd n out_data", {48'd0, n_out_data}, {48'd0, nq[0]});
            else if (n_clr) chk("rnd n out_data clr", {48'd0, n_out_data}, {48'd0, N_RV});
            s_acc = s_in_valid && (sq.size() < 2);
            s_pop = (sq.size() > 0) && s_out_ready;
            n_acc = n_in_valid && ((nq.size() == 0) || n_out_ready);
            n_pop = (nq.size() > 0) && n_out_ready;
            @(posedge clk);
            if (s_reset || s_flush) begin
                sq.delete(); s_clr = 1'b1;
            end else begin
                if (s_pop) void'(sq.pop_front());
                if (s_acc) begin sq.push_back(s_in_data); s_clr = 1'b0; end
            end
            if (n_reset) begin
                nq.delete(); n_clr = 1'b1;
            end else if (n_flush) begin
                nq.delete();
            end else begin
                if (n_pop) void'(nq.pop_front());
                if (n_acc) begin nq.push_back(n_in_data); n_clr = 1'b0; end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
